// File: rtl/unstripe_ctrl_if.sv
// rtl/unstripe_ctrl_if.sv - lane inputs and unstriped output bundle for unstripe_ctrl
interface unstripe_ctrl_if;
  logic [7:0] lane_0;
  logic       valid_0;
  logic [7:0] lane_1;
  logic       valid_1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_sel;
  logic       sync_ok;
  logic [3:0] err_cnt;

  modport master (
    output lane_0, valid_0, lane_1, valid_1,
    input  data_out, valid_out, lane_sel, sync_ok, err_cnt
  );

  modport slave (
    input  lane_0, valid_0, lane_1, valid_1,
    output data_out, valid_out, lane_sel, sync_ok, err_cnt
  );
endinterface

// File: rtl/unstripe_ctrl.sv
// rtl/unstripe_ctrl.sv - merges two striped byte lanes back into one stream, lane 0 first
module unstripe_ctrl #(
  parameter int SYNC_PAIRS = 2,
  parameter int TIMEOUT    = 3
) (
  input  logic             clk_2f,
  input  logic             reset,
  unstripe_ctrl_if.slave   bus
);

  localparam logic [3:0] PAIRS_MAX = 4'(SYNC_PAIRS);
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  typedef enum logic {RD0 = 1'b0, RD1 = 1'b1} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] pair_cnt;
  logic [3:0] pair_next;
  logic [7:0] data_q;
  logic       valid_q;
  logic       sel_q;
  logic       sync_q;
  logic [3:0] err_q;

  always_comb begin
    pair_next = (pair_cnt >= PAIRS_MAX) ? PAIRS_MAX : pair_cnt + 4'd1;
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state    <= RD0;
      wait_cnt <= 4'd0;
      pair_cnt <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      sel_q    <= 1'b0;
      sync_q   <= 1'b0;
      err_q    <= 4'd0;
    end else begin
      case (state)
        RD0: begin
          if (bus.valid_0) begin
            data_q  <= bus.lane_0;
            valid_q <= 1'b1;
            sel_q   <= 1'b0;
            state   <= RD1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        RD1: begin
          if (bus.valid_1) begin
            data_q   <= bus.lane_1;
            valid_q  <= 1'b1;
            sel_q    <= 1'b1;
            wait_cnt <= 4'd0;
            pair_cnt <= pair_next;
            if (pair_next == PAIRS_MAX) sync_q <= 1'b1;
            state    <= RD0;
          end else begin
            valid_q <= 1'b0;
            // Lane 1 went silent too long: drop the half pair and relock from lane 0.
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt <= 4'd0;
              pair_cnt <= 4'd0;
              sync_q   <= 1'b0;
              if (err_q != 4'hF) err_q <= err_q + 4'd1;
              state    <= RD0;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end
        default: state <= RD0;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.lane_sel  = sel_q;
  assign bus.sync_ok   = sync_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_unstripe_ctrl.sv
// tb/tb_unstripe_ctrl.sv - randomized and directed checks of unstripe_ctrl against a lane-pairing model
module tb_unstripe_ctrl;
  localparam int SYNC_PAIRS = 2;
  localparam int TIMEOUT    = 3;

  logic clk_2f = 1'b0;
  logic reset  = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  unstripe_ctrl_if bus ();

  unstripe_ctrl #(.SYNC_PAIRS(SYNC_PAIRS), .TIMEOUT(TIMEOUT)) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk_2f = ~clk_2f;

  // Reference: which lane is owed next, how long lane 1 has been idle, how many pairs completed.
  bit       m_want_lane1;
  int       m_idle;
  int       m_pairs;
  bit       m_sync;
  int       m_err;
  bit [7:0] m_dout;
  bit       m_vout;
  bit       m_lsel;
  bit       prev_vout;
  bit       prev_lsel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_want_lane1 = 0; m_idle = 0; m_pairs = 0; m_sync = 0; m_err = 0;
    m_dout = 8'h00; m_vout = 0; m_lsel = 0;
    prev_vout = 0; prev_lsel = 0;
  endtask

  task automatic model_edge(input bit v0, input bit [7:0] l0, input bit v1, input bit [7:0] l1);
    if (!m_want_lane1) begin
      m_vout = v0;
      if (v0) begin
        m_dout = l0; m_lsel = 0; m_want_lane1 = 1;
      end
    end else if (v1) begin
      m_dout = l1; m_vout = 1; m_lsel = 1; m_want_lane1 = 0; m_idle = 0;
      m_pairs = (m_pairs + 1 > SYNC_PAIRS) ? SYNC_PAIRS : m_pairs + 1;
      if (m_pairs == SYNC_PAIRS) m_sync = 1;
    end else begin
      m_vout = 0;
      m_idle = m_idle + 1;
      if (m_idle == TIMEOUT) begin
        m_idle = 0; m_pairs = 0; m_sync = 0; m_want_lane1 = 0;
        m_err = (m_err == 15) ? 15 : m_err + 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid_out"}, 32'(bus.valid_out), 32'(m_vout));
    check({tag, ".lane_sel"},  32'(bus.lane_sel),  32'(m_lsel));
    check({tag, ".sync_ok"},   32'(bus.sync_ok),   32'(m_sync));
    check({tag, ".err_cnt"},   32'(bus.err_cnt),   32'(m_err));
    if (m_vout) check({tag, ".data_out"}, 32'(bus.data_out), 32'(m_dout));
    if (bus.valid_out && prev_vout)
      check({tag, ".alternate"}, 32'(bus.lane_sel != prev_lsel), 32'd1);
    prev_vout = bus.valid_out;
    prev_lsel = bus.lane_sel;
  endtask

  // Inputs change on the falling edge; outputs are compared on the following falling edge.
  task automatic cycle(input string tag, input bit v0, input bit [7:0] l0, input bit v1, input bit [7:0] l1);
    bus.valid_0 = v0; bus.lane_0 = l0; bus.valid_1 = v1; bus.lane_1 = l1;
    @(posedge clk_2f);
    if (reset) model_edge(v0, l0, v1, l1);
    else model_reset();
    @(negedge clk_2f);
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs({tag, ".async"});
    check({tag, ".data_clr"}, 32'(bus.data_out), 32'h0);
    cycle({tag, ".held"}, 1, 8'h5A, 1, 8'hA5);
    reset = 1'b1;
  endtask

  initial begin
    bus.valid_0 = 0; bus.lane_0 = 8'h00; bus.valid_1 = 0; bus.lane_1 = 8'h00;
    model_reset();
    @(negedge clk_2f);
    cycle("rst0", 0, 8'h00, 0, 8'h00);
    cycle("rst1", 1, 8'hFF, 0, 8'h00);
    check("rst.data", 32'(bus.data_out), 32'h0);
    reset = 1'b1;

    cycle("p0", 1, 8'hFF, 0, 8'h00);
    cycle("p1", 0, 8'h00, 1, 8'hEE);
    cycle("p2", 1, 8'hDD, 0, 8'h00);
    check("p2.nosync", 32'(bus.sync_ok), 32'd0);
    cycle("p3", 0, 8'h00, 1, 8'hCC);
    check("p3.sync", 32'(bus.sync_ok), 32'd1);

    cycle("to0", 1, 8'h03, 0, 8'h00);
    for (int i = 0; i < TIMEOUT; i++) cycle("to.idle", 0, 8'h00, 0, 8'h00);
    check("to.err", 32'(bus.err_cnt), 32'd1);
    check("to.sync", 32'(bus.sync_ok), 32'd0);
    cycle("to.ign", 0, 8'h00, 1, 8'h77);
    check("to.ign_v", 32'(bus.valid_out), 32'd0);

    for (int p = 0; p < 2; p++) begin
      cycle("g.l0", 1, 8'hAA, 1, 8'h11);
      cycle("g.l1", 1, 8'h22, 1, 8'h99);
    end
    for (int i = 0; i < 2; i++) cycle("gap", 0, 8'h00, 0, 8'h00);
    cycle("g2.l0", 1, 8'hAA, 0, 8'h00);
    cycle("g2.l1", 0, 8'h00, 1, 8'h99);
    check("gap.sync", 32'(bus.sync_ok), 32'd1);

    for (int t = 0; t < 17; t++) begin
      cycle("sat.l0", 1, 8'(t), 0, 8'h00);
      for (int i = 0; i < TIMEOUT; i++) cycle("sat.idle", 0, 8'h00, 0, 8'h00);
    end
    check("sat.err", 32'(bus.err_cnt), 32'd15);

    cycle("mid.l0", 1, 8'hAA, 0, 8'h00);
    async_reset("mid");
    cycle("mid.l1only", 0, 8'h00, 1, 8'h99);
    check("mid.nov", 32'(bus.valid_out), 32'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) async_reset("rnd");
      else cycle("rnd", $urandom_range(0, 2) != 0, 8'($urandom),
                 $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
